// File: rtl/fir_capture_buf.sv
// fir_capture_buf: triggered capture of FIR output samples into a DEPTH-entry
// buffer. Control, status and buffer readback go through a Wishbone classic
// slave port with single-cycle registered ack/err responses.
module fir_capture_buf #(
  parameter int DEPTH         = 64,
  parameter int WB_ADDR_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              data_in,
  input  logic [WB_ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [15:0]              wb_dat_i,
  input  logic                     wb_we_i,
  input  logic [1:0]               wb_sel_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_cyc_i,
  output logic [15:0]              wb_dat_o,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  output logic                     capture_done,
  output logic [63:0]              testvec
);

  localparam int IDX_W    = $clog2(DEPTH);
  localparam int CNT_W    = IDX_W + 1;
  localparam int WIN_BASE = 'h40;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   count, count_nx;
  logic [7:0]         decim_cnt, decim_cnt_nx;
  logic [15:0]        last_written;
  logic               trig_mode;
  logic [7:0]         decim;
  logic signed [15:0] thresh;
  logic signed [15:0] sample;
  logic [15:0]        mem [DEPTH];
  logic               buf_we;
  logic [IDX_W-1:0]   buf_idx;
  logic               bus_txn, adr_ctrl, adr_thresh, adr_status, adr_win, adr_ok;
  logic               bus_err, bus_ok, wr_ok, ctrl_wr, arm, abort, trigger;
  logic [15:0]        rdata;

  assign sample       = data_in;
  assign capture_done = (state == S_DONE);
  // Gated so every output reads zero the moment reset asserts.
  assign testvec      = rst ? 64'd0 : {data_in, last_written, count, state, decim_cnt,
                                       wb_ack_o, wb_err_o, capture_done, 12'd0};

  // Address decode and transaction qualification; a transaction is accepted
  // only when no response is pending, so each request gets exactly one pulse.
  always_comb begin
    bus_txn    = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    adr_ctrl   = (int'(wb_adr_i) == 'h00);
    adr_thresh = (int'(wb_adr_i) == 'h01);
    adr_status = (int'(wb_adr_i) == 'h02);
    adr_win    = (int'(wb_adr_i) >= WIN_BASE) && (int'(wb_adr_i) < WIN_BASE + DEPTH);
    adr_ok     = adr_ctrl | adr_thresh | adr_status | adr_win;
    bus_err    = bus_txn & (~adr_ok | (wb_we_i & (adr_status | adr_win)));
    bus_ok     = bus_txn & ~bus_err;
    wr_ok      = bus_ok & wb_we_i;
    ctrl_wr    = wr_ok & adr_ctrl & wb_sel_i[0];
    arm        = ctrl_wr & wb_dat_i[0];
    abort      = ctrl_wr & wb_dat_i[1];
    trigger    = ~trig_mode | (sample > thresh);
  end

  // Read data mux; ARM/ABORT are pulses and always read back as zero.
  always_comb begin
    rdata = 16'd0;
    if (adr_ctrl)        rdata = {decim, 5'd0, trig_mode, 2'd0};
    else if (adr_thresh) rdata = thresh;
    else if (adr_status) rdata = {1'b0, count, 5'd0, capture_done, state};
    else if (adr_win)    rdata = mem[wb_adr_i[IDX_W-1:0]];
  end

  // Capture FSM next state; ABORT outranks ARM, both outrank sampling.
  always_comb begin
    state_nx     = state;
    count_nx     = count;
    decim_cnt_nx = decim_cnt;
    buf_we       = 1'b0;
    buf_idx      = count[IDX_W-1:0];
    if (abort) begin
      state_nx = S_IDLE;
    end else if (arm) begin
      state_nx     = S_ARMED;
      count_nx     = '0;
      decim_cnt_nx = 8'd0;
    end else begin
      case (state)
        S_ARMED: begin
          if (trigger) begin
            buf_we       = 1'b1;
            buf_idx      = '0;
            count_nx     = CNT_W'(1);
            decim_cnt_nx = 8'd0;
            state_nx     = S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (decim_cnt == decim) begin
            buf_we       = 1'b1;
            count_nx     = count + 1'b1;
            decim_cnt_nx = 8'd0;
            if (count == CNT_W'(DEPTH - 1)) state_nx = S_DONE;
          end else begin
            decim_cnt_nx = decim_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Capture FSM state, sample counters and last captured sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      count        <= '0;
      decim_cnt    <= 8'd0;
      last_written <= 16'd0;
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      decim_cnt <= decim_cnt_nx;
      if (buf_we) last_written <= data_in;
    end
  end

  // Control and threshold registers with per-byte write enables.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_mode <= 1'b0;
      decim     <= 8'd0;
      thresh    <= 16'sd0;
    end else begin
      if (wr_ok && adr_ctrl) begin
        if (wb_sel_i[0]) trig_mode <= wb_dat_i[2];
        if (wb_sel_i[1]) decim     <= wb_dat_i[15:8];
      end
      if (wr_ok && adr_thresh) begin
        if (wb_sel_i[0]) thresh[7:0]  <= wb_dat_i[7:0];
        if (wb_sel_i[1]) thresh[15:8] <= wb_dat_i[15:8];
      end
    end
  end

  // Registered bus response, one cycle after the accepted transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= 16'd0;
    end else begin
      wb_ack_o <= bus_ok;
      wb_err_o <= bus_err;
      wb_dat_o <= (bus_ok && !wb_we_i) ? rdata : 16'd0;
    end
  end

  // Sample buffer storage; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (buf_we) mem[buf_idx] <= data_in;
  end

endmodule

// File: doc/fir_capture_buf.md
FIR_CAPTURE_BUF -- requirements
Module: fir_capture_buf

Interface
REQ-001 Parameter DEPTH, 64, capture buffer entries; fixed at 64 for this release.
REQ-002 Parameter WB_ADDR_WIDTH, 8, Wishbone address width.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 data_in  in  16  signed FIR output sample, new sample every clk.
REQ-006 wb_adr_i  in  8  word address. wb_dat_i in 16 write data. wb_we_i in 1 write enable.
REQ-007 wb_sel_i  in  2  byte enables for writes. wb_stb_i in 1 strobe. wb_cyc_i in 1 cycle.
REQ-008 wb_dat_o  out  16  read data. wb_ack_o out 1 ack. wb_err_o out 1 error.
REQ-009 capture_done  out  1  level, high while state is DONE.
REQ-010 testvec  out  64  logic-analyser vector.

Function
REQ-011 Register map: 0x00 CTRL, 0x01 THRESH, 0x02 STATUS (RO), 0x40-0x7F buffer window (RO, entry = adr-0x40).
REQ-012 CTRL: bit0 ARM (write-1 pulse, reads 0), bit1 ABORT (write-1 pulse, reads 0), bit2 TRIG_MODE (0 immediate, 1 threshold), bits[15:8] DECIM.
REQ-013 THRESH: 16-bit signed threshold, read/write.
REQ-014 STATUS: bits[1:0] state, bit2 done, bits[14:8] count (0..64), others 0.
REQ-015 Bus transaction = wb_cyc_i & wb_stb_i & !wb_ack_o & !wb_err_o; response exactly one cycle later, single-cycle pulse.
REQ-016 Response: wb_ack_o for valid access; wb_err_o (no ack) for unmapped address, or write to STATUS/window; erroneous writes change nothing.
REQ-017 Writes: byte with wb_sel_i bit 0 is left unchanged; ARM/ABORT act only if sel[0]=1.
REQ-018 wb_dat_o registered, valid with ack; window read returns stored entry, readable in any state.
REQ-019 States IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
REQ-020 ARM in any state -> ARMED next cycle; count:=0, decim_cnt:=0, done cleared.
REQ-021 ARMED: trigger = TRIG_MODE==0, or signed data_in > signed THRESH (strict).
REQ-022 On trigger: data_in written to entry 0, count:=1, decim_cnt:=0, -> CAPTURE.
REQ-023 CAPTURE: each cycle decim_cnt==DECIM -> write data_in to entry[count], count+1, decim_cnt:=0; else decim_cnt+1.
REQ-024 Write making count==64 -> DONE same edge; no further writes; count holds 64.
REQ-025 DECIM=0 captures every sample; DECIM=N captures every (N+1)th sample after trigger.
REQ-026 ABORT -> IDLE next cycle from any state; count and buffer retained; ABORT beats simultaneous ARM.
REQ-027 Sample written at edge k readable by a bus read issued at cycle k+1 or later.
REQ-028 THRESH/TRIG_MODE/DECIM changes take effect the cycle after the write ack.
REQ-029 testvec = {data_in[15:0], last_written[15:0], count[6:0], state[1:0], decim_cnt[7:0], wb_ack_o, wb_err_o, capture_done, 12'd0}.

Reset
REQ-030 rst asserted: state IDLE, CTRL/THRESH/count/decim_cnt/last_written 0, all outputs 0, immediately (asynchronous).
REQ-031 Buffer contents not reset; undefined until written; bench must not check them after reset.
REQ-032 rst mid-capture aborts capture; ARM required after release.

Verification
REQ-033 Immediate, DECIM=0, ramp data_in=0,1,2...; ARM -> DONE after 64 samples; window 0x40..0x7F reads 64 consecutive ramp values; STATUS=0x4007.
REQ-034 Threshold THRESH=0x0100, ramp from 0xFFF0 (signed): trigger on first sample 0x0101; entry0=0x0101, entry63=0x0140.
REQ-035 DECIM=3, ramp: entries differ by 4; DONE reached 253 cycles after trigger cycle.
REQ-036 ABORT at count=10 with simultaneous ARM -> IDLE, STATUS count=10; then ARM -> count=0, ARMED.
REQ-037 Read 0x03, write 0x02, write 0x45 -> wb_err_o one-cycle pulse, no ack, registers unchanged; write CTRL sel=2'b10 data 0x0005 -> no ARM.
REQ-038 rst pulse during CAPTURE -> outputs 0 asynchronously, state IDLE, capture_done 0.
